corner_drain_arb: RTL and testbench

- Drains the two per-camera corner-record FIFOs (128-bit records, read side in read-clock domain `c`) into one 32-bit valid/ready word stream for the host DMA path.
- Grants between camera 0 and camera 1 round-robin, with bounded bursts per grant and a high-water override so a filling FIFO is served first.
- Sits between the corner detector pair's read port (`q`, `q_read`, `q_empty`, `q_avail`) and the host streaming interface.

---
 rtl/corner_drain_pkg.sv | 28 ++
 rtl/corner_rr_pick.sv | 34 +++
 rtl/corner_drain_arb.sv | 159 +++++++++++++++
 tb/tb_corner_drain_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corner_drain_pkg.sv
// Shared types and sizes for the corner-record drain arbiter.
package corner_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int REC_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_REC = REC_W / WORD_W;
  localparam int NCAM          = 2;
  localparam int AVAIL_W       = 7;

  // Two-way round-robin among the candidate cameras. With both candidates
  // present the one that was not served last wins; with one candidate it
  // wins outright. An empty candidate set returns 0 and is masked by the
  // caller's valid flag.
  function automatic logic rr_choose(input logic [NCAM-1:0] cand,
                                     input logic            last_served);
    if (cand == 2'b11) begin
      return ~last_served;
    end
    return cand[1];
  endfunction

endpackage

// File: rtl/corner_rr_pick.sv
// Grant selection for the drain arbiter: a camera at or above the high-water
// level wins over round-robin; ties at either level fall back to round-robin.
module corner_rr_pick
  import corner_drain_pkg::*;
#(
  parameter int HI_WATER = 96
) (
  input  logic [NCAM-1:0]         q_empty,
  input  logic [NCAM*AVAIL_W-1:0] q_avail,
  input  logic                    last_served,
  output logic                    pick,
  output logic                    pick_valid
);

  localparam logic [AVAIL_W-1:0] HI_LVL = AVAIL_W'(HI_WATER);

  logic [NCAM-1:0] nonempty;
  logic [NCAM-1:0] hot;
  logic [NCAM-1:0] cand;

  // Classify each camera, then restrict to the high-water set when it is non-empty.
  always_comb begin
    nonempty = '0;
    hot      = '0;
    for (int i = 0; i < NCAM; i++) begin
      nonempty[i] = ~q_empty[i];
      hot[i]      = nonempty[i] && (q_avail[i*AVAIL_W +: AVAIL_W] >= HI_LVL);
    end
    cand       = (hot != '0) ? hot : nonempty;
    pick_valid = |nonempty;
    pick       = rr_choose(cand, last_served);
  end

endmodule

// File: rtl/corner_drain_arb.sv
// Drains two per-camera 128-bit corner FIFOs into one 32-bit valid/ready
// stream, four words per record, with bounded bursts per grant.
//
// state | meaning
// IDLE  | no grant; picks a camera when enabled and any FIFO has data
// LOAD  | pops one record from the granted camera into the record register
// SEND  | streams the 4 words of the held record, word 0 = bits [31:0]
module corner_drain_arb
  import corner_drain_pkg::*;
#(
  parameter int BURST    = 16,
  parameter int HI_WATER = 96
) (
  input  logic                        c,
  input  logic                        r,
  input  logic                        en,
  input  logic [NCAM*REC_W-1:0]       q,
  input  logic [NCAM-1:0]             q_empty,
  input  logic [NCAM*AVAIL_W-1:0]     q_avail,
  output logic [NCAM-1:0]             q_read,
  output logic [WORD_W-1:0]           od,
  output logic                        ov,
  input  logic                        ordy,
  output logic                        olast,
  output logic                        osrc,
  output logic                        busy,
  output logic [31:0]                 rec_count
);

  localparam int              CNT_W    = 8;
  localparam logic [1:0]      LAST_IDX = 2'(WORDS_PER_REC - 1);
  localparam logic [CNT_W:0]  BURST_LIM = (CNT_W+1)'(BURST);

  state_t             state;
  state_t             state_n;
  logic [REC_W-1:0]   rec;
  logic [1:0]         widx;
  logic [CNT_W-1:0]   burst_cnt;
  logic [CNT_W:0]     burst_next;
  logic               last_served;
  logic               osrc_r;
  logic               pick;
  logic               pick_valid;
  logic               grant;
  logic               rec_done;
  logic               burst_more;

  corner_rr_pick #(
    .HI_WATER (HI_WATER)
  ) u_pick (
    .q_empty     (q_empty),
    .q_avail     (q_avail),
    .last_served (last_served),
    .pick        (pick),
    .pick_valid  (pick_valid)
  );

  assign burst_next = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign burst_more = burst_next < BURST_LIM;

  // State register.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; en and the granted FIFO's empty flag only matter at record boundaries.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    rec_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && pick_valid) begin
          state_n = LOAD;
          grant   = 1'b1;
        end
      end
      LOAD: begin
        state_n = SEND;
      end
      SEND: begin
        if (ordy && (widx == LAST_IDX)) begin
          rec_done = 1'b1;
          if (burst_more && en && !q_empty[osrc_r]) begin
            state_n = LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Grant bookkeeping: camera select, burst length and round-robin history.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      osrc_r      <= 1'b0;
      burst_cnt   <= '0;
      last_served <= 1'b1;
    end else begin
      if (grant) begin
        osrc_r    <= pick;
        burst_cnt <= '0;
      end else if (rec_done) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
      if (rec_done && (state_n == IDLE)) begin
        last_served <= osrc_r;
      end
    end
  end

  // Record capture, word sequencing and the forwarded-record counter.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      rec       <= '0;
      widx      <= '0;
      rec_count <= '0;
    end else begin
      if (state == LOAD) begin
        rec  <= osrc_r ? q[2*REC_W-1:REC_W] : q[REC_W-1:0];
        widx <= '0;
      end else if ((state == SEND) && ordy) begin
        widx <= widx + 2'd1;
      end
      if (rec_done) begin
        rec_count <= rec_count + 32'd1;
      end
    end
  end

  // Outputs decode from registered state only, so they hold while ordy is low
  // and drop at once when reset is asserted.
  always_comb begin
    q_read = '0;
    ov     = 1'b0;
    od     = '0;
    olast  = 1'b0;
    if (state == LOAD) begin
      q_read[osrc_r] = 1'b1;
    end
    if (state == SEND) begin
      ov    = 1'b1;
      od    = rec[{widx, 5'd0} +: WORD_W];
      olast = (widx == LAST_IDX);
    end
  end

  assign osrc = osrc_r;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_corner_drain_arb.sv
// Directed bench for corner_drain_arb with a record-level scoreboard.
module tb_corner_drain_arb;

  localparam int BURST    = 16;
  localparam int HI_WATER = 96;

  logic         c = 1'b0;
  logic         r = 1'b1;
  logic         en = 1'b0;
  logic         ordy = 1'b1;
  logic [255:0] q;
  logic [1:0]   q_empty;
  logic [13:0]  q_avail;
  logic [1:0]   q_read;
  logic [31:0]  od;
  logic         ov;
  logic         olast;
  logic         osrc;
  logic         busy;
  logic [31:0]  rec_count;

  int total = 0;
  int bad   = 0;

  logic [127:0] fifo0[$];
  logic [127:0] fifo1[$];
  logic [6:0]   av0 = '0;
  logic [6:0]   av1 = '0;
  logic [1:0]   pend = '0;

  typedef struct {
    logic         cam;
    logic [127:0] rec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_tmp;
  int   widx_m      = 0;
  int   model_count = 0;
  int   pop_log[$];
  int   sz_tmp;

  logic [31:0]  w1[4];
  logic [127:0] rec_a;
  logic [127:0] rec_b;
  logic [127:0] rec_c;
  int           run_cam[6];
  int           run_len[6];
  int           idx;
  int           k;
  int           n;

  corner_drain_arb #(
    .BURST    (BURST),
    .HI_WATER (HI_WATER)
  ) dut (
    .c         (c),
    .r         (r),
    .en        (en),
    .q         (q),
    .q_empty   (q_empty),
    .q_avail   (q_avail),
    .q_read    (q_read),
    .od        (od),
    .ov        (ov),
    .ordy      (ordy),
    .olast     (olast),
    .osrc      (osrc),
    .busy      (busy),
    .rec_count (rec_count)
  );

  always #5 c = ~c;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic update_q();
    q_empty[0] = (fifo0.size() == 0);
    q_empty[1] = (fifo1.size() == 0);
    q[127:0]   = (fifo0.size() > 0) ? fifo0[0] : '0;
    q[255:128] = (fifo1.size() > 0) ? fifo1[0] : '0;
    q_avail    = {av1, av0};
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  function automatic logic [127:0] mkrec(input int cam, input int id);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) begin
      v[w*32 +: 32] = {4'(cam), 4'(w), 8'(id), 16'hC0DE};
    end
    return v;
  endfunction

  task automatic do_reset();
    step();
    r    = 1'b1;
    en   = 1'b1;
    ordy = 1'b1;
    av0  = '0;
    av1  = '0;
    fifo0.delete();
    fifo1.delete();
    pop_log.delete();
    update_q();
    step();
    step();
  endtask

  task automatic wait_count(input int target, input int budget);
    int cyc;
    cyc = 0;
    while (((model_count < target) || busy) && (cyc < budget)) begin
      step();
      cyc++;
    end
    chk("wait_budget", cyc < budget, 1'b1);
  endtask

  // FIFO side: a pop strobed during a cycle takes effect just after the edge
  // that ends it, so the DUT latches the head before it advances.
  always @(posedge c) begin
    #1;
    if (pend[0] && (fifo0.size() > 0)) void'(fifo0.pop_front());
    if (pend[1] && (fifo1.size() > 0)) void'(fifo1.pop_front());
    update_q();
  end

  // Scoreboard: every popped record must come out as 4 words in order, from
  // the camera it was popped from, with rec_count tracking completed records.
  always @(negedge c) begin
    if (r) begin
      exp_q.delete();
      widx_m      = 0;
      model_count = 0;
      pend        = '0;
      chk("rst_ov", ov, 1'b0);
      chk("rst_q_read", q_read, 2'b00);
      chk("rst_rec_count", rec_count, 32'd0);
      chk("rst_busy", busy, 1'b0);
    end else begin
      pend = q_read;
      chk("rec_count", rec_count, model_count);
      chk("busy", busy, ov || (q_read != 2'b00));
      if (q_read != 2'b00) begin
        chk("q_read_onehot", (q_read == 2'b01) || (q_read == 2'b10), 1'b1);
        chk("q_read_with_ov", ov, 1'b0);
        sz_tmp = q_read[1] ? fifo1.size() : fifo0.size();
        chk("pop_nonempty", sz_tmp > 0, 1'b1);
        if (sz_tmp > 0) begin
          e_tmp.cam = q_read[1];
          e_tmp.rec = q_read[1] ? fifo1[0] : fifo0[0];
          exp_q.push_back(e_tmp);
        end
        pop_log.push_back(int'(q_read[1]));
      end
      if (ov) begin
        chk("ov_has_record", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("od", od, exp_q[0].rec[widx_m*32 +: 32]);
          chk("olast", olast, widx_m == 3);
          chk("osrc", osrc, exp_q[0].cam);
          if (ordy) begin
            widx_m++;
            if (widx_m == 4) begin
              widx_m = 0;
              void'(exp_q.pop_front());
              model_count++;
            end
          end
        end
      end else begin
        chk("no_partial_record", widx_m, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    w1[0] = 32'h11111111;
    w1[1] = 32'h22222222;
    w1[2] = 32'h33333333;
    w1[3] = 32'h44444444;
    run_cam = '{0, 1, 0, 1, 0, 1};
    run_len = '{16, 16, 16, 16, 8, 8};
    update_q();
    step();
    step();
    chk("reset_od", od, 32'd0);
    chk("reset_olast", olast, 1'b0);
    chk("reset_osrc", osrc, 1'b0);
    chk("reset_ov", ov, 1'b0);

    // single record out of reset, checks latency and word order
    fifo0.push_back({w1[3], w1[2], w1[1], w1[0]});
    en   = 1'b1;
    ordy = 1'b1;
    update_q();
    r = 1'b0;
    step();
    chk("t1_q_read", q_read, 2'b01);
    for (int w = 0; w < 4; w++) begin
      step();
      chk("t1_od", od, w1[w]);
      chk("t1_ov", ov, 1'b1);
      chk("t1_olast", olast, w == 3);
      chk("t1_osrc", osrc, 1'b0);
    end
    step();
    chk("t1_idle_ov", ov, 1'b0);
    chk("t1_rec_count", rec_count, 32'd1);
    chk("t1_pops", pop_log.size(), 1);

    // 40 records each: bursts of 16 alternate, then the 8-record tails
    do_reset();
    for (int i = 0; i < 40; i++) begin
      fifo0.push_back(mkrec(0, i));
      fifo1.push_back(mkrec(1, i));
    end
    av0 = 7'd40;
    av1 = 7'd40;
    update_q();
    r = 1'b0;
    wait_count(80, 1500);
    chk("t2_rec_count", rec_count, 32'd80);
    chk("t2_pops", pop_log.size(), 80);
    idx = 0;
    for (int j = 0; j < 6; j++) begin
      for (int m = 0; m < run_len[j]; m++) begin
        if (idx < pop_log.size()) chk("t2_grant_order", pop_log[idx], run_cam[j]);
        idx++;
      end
    end

    // high-water override beats round-robin
    do_reset();
    fifo0.push_back(mkrec(0, 50));
    fifo1.push_back(mkrec(1, 50));
    av0 = 7'd20;
    av1 = 7'd100;
    update_q();
    r = 1'b0;
    wait_count(2, 100);
    chk("t3_pops", pop_log.size(), 2);
    if (pop_log.size() >= 2) begin
      chk("t3_first_cam", pop_log[0], 1);
      chk("t3_second_cam", pop_log[1], 0);
    end

    // ordy stall at word 1
    do_reset();
    rec_a = mkrec(0, 60);
    fifo0.push_back(rec_a);
    fifo0.push_back(mkrec(0, 61));
    av0 = 7'd10;
    update_q();
    r = 1'b0;
    k = 0;
    while (!(ov && (od == rec_a[63:32])) && (k < 50)) begin
      step();
      k++;
    end
    chk("t4_reach_word1", k < 50, 1'b1);
    ordy = 1'b0;
    n = pop_log.size();
    repeat (10) begin
      step();
      chk("t4_hold_od", od, rec_a[63:32]);
      chk("t4_hold_ov", ov, 1'b1);
      chk("t4_hold_olast", olast, 1'b0);
    end
    chk("t4_no_pop", pop_log.size(), n);
    ordy = 1'b1;
    step();
    chk("t4_resume_word2", od, rec_a[95:64]);
    wait_count(2, 100);
    chk("t4_rec_count", rec_count, 32'd2);

    // en dropped at word 2: record finishes, no further pops
    do_reset();
    rec_b = mkrec(0, 70);
    fifo0.push_back(rec_b);
    fifo0.push_back(mkrec(0, 71));
    fifo0.push_back(mkrec(0, 72));
    av0 = 7'd10;
    update_q();
    r = 1'b0;
    k = 0;
    while (!(ov && (od == rec_b[95:64])) && (k < 50)) begin
      step();
      k++;
    end
    chk("t5_reach_word2", k < 50, 1'b1);
    en = 1'b0;
    step();
    chk("t5_word3", od, rec_b[127:96]);
    chk("t5_word3_last", olast, 1'b1);
    step();
    chk("t5_idle_ov", ov, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);
    repeat (10) step();
    chk("t5_no_pop", pop_log.size(), 1);
    chk("t5_count_held", rec_count, 32'd1);
    en = 1'b1;
    wait_count(3, 100);
    chk("t5_rec_count", rec_count, 32'd3);

    // reset during cam1's word 1; camera 0 must win afterwards
    do_reset();
    rec_c = mkrec(1, 80);
    fifo0.push_back(mkrec(0, 80));
    fifo1.push_back(rec_c);
    fifo1.push_back(mkrec(1, 81));
    av0 = 7'd10;
    av1 = 7'd10;
    update_q();
    r = 1'b0;
    k = 0;
    while (!(ov && osrc && (od == rec_c[63:32])) && (k < 60)) begin
      step();
      k++;
    end
    chk("t6_reach_cam1_word1", k < 60, 1'b1);
    fifo0.push_back(mkrec(0, 81));
    update_q();
    r = 1'b1;
    #1;
    chk("t6_async_ov", ov, 1'b0);
    chk("t6_async_q_read", q_read, 2'b00);
    chk("t6_async_rec_count", rec_count, 32'd0);
    chk("t6_async_busy", busy, 1'b0);
    pop_log.delete();
    step();
    step();
    r = 1'b0;
    k = 0;
    while ((pop_log.size() == 0) && (k < 20)) begin
      step();
      k++;
    end
    chk("t6_regrant", pop_log.size() > 0, 1'b1);
    if (pop_log.size() > 0) chk("t6_first_cam", pop_log[0], 0);
    wait_count(2, 100);
    chk("t6_rec_count", rec_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
